// File: rtl/phys_free_list_pkg.sv
// Shared configuration for the physical-register free list.
// Holds the project-wide register counts, the derived free-list depth,
// the controller state encoding and a pointer-width helper.
package phys_free_list_pkg;

  localparam int PROJ_NUM_PHYS_REGS = 64;
  localparam int PROJ_NUM_ARCH_REGS = 32;
  localparam int PROJ_LOG_PHYS      = 6;
  localparam int FREE_LIST_DEPTH    = PROJ_NUM_PHYS_REGS - PROJ_NUM_ARCH_REGS;

  typedef enum logic {
    FL_INIT = 1'b0,
    FL_RUN  = 1'b1
  } fl_state_e;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/free_list_ram.sv
// Tag storage for the free list: DEPTH entries of DATA_W bits,
// one synchronous write port and one asynchronous read port.
// Ports:
//   CLK   clock
//   we    write enable
//   waddr write slot
//   wdata tag to store
//   raddr read slot
//   rdata tag stored at raddr (combinational)
module free_list_ram
  import phys_free_list_pkg::*;
#(
  parameter int  DEPTH  = FREE_LIST_DEPTH,
  parameter int  DATA_W = PROJ_LOG_PHYS,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/phys_free_list.sv
// Physical-register free-list controller.
// Circular FIFO of destination tags with a speculative head (advanced by
// rename allocations), a committed head (advanced by commits of allocating
// instructions) and a tail (advanced by released tags). A flush rewinds the
// speculative head to the committed head. After reset the list fills itself
// with tags NUM_ARCH..NUM_PHYS-1 over DEPTH cycles.
// Optional build macro: PHYS_FREE_LIST_BYPASS_EN lets a tag released into an
// empty list be granted in the same cycle.
// Ports:
//   CLK, RESET        clock, asynchronous active-low reset
//   Alloc_req         rename wants one tag this cycle
//   Alloc_grant       Free_phys_reg is consumed at this edge
//   Free_phys_reg     tag at the speculative head
//   Free_reg_avail    at least one tag allocatable
//   Free_count        tail minus speculative head
//   Commit_alloc      committing instruction had allocated a tag
//   Release_valid     commit frees Release_phys_reg
//   Release_phys_reg  tag being freed
//   Flush             recovery; rewind speculative head
//   Init_done         initial fill complete
//   Overflow_err      sticky; a release hit a full list
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int  NUM_PHYS = PROJ_NUM_PHYS_REGS,
  parameter int  NUM_ARCH = PROJ_NUM_ARCH_REGS,
  parameter int  LOG_PHYS = PROJ_LOG_PHYS,
  localparam int DEPTH    = NUM_PHYS - NUM_ARCH,
  localparam int PTR_W    = ptr_width(DEPTH)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Alloc_req,
  output logic                Alloc_grant,
  output logic [LOG_PHYS-1:0] Free_phys_reg,
  output logic                Free_reg_avail,
  output logic [PTR_W-1:0]    Free_count,
  input  logic                Commit_alloc,
  input  logic                Release_valid,
  input  logic [LOG_PHYS-1:0] Release_phys_reg,
  input  logic                Flush,
  output logic                Init_done,
  output logic                Overflow_err
);

  localparam int IDX_W = PTR_W - 1;

  function automatic logic [LOG_PHYS-1:0] init_tag(input logic [IDX_W-1:0] k);
    return LOG_PHYS'(NUM_ARCH) + LOG_PHYS'(k);
  endfunction

  fl_state_e           state;
  logic [IDX_W-1:0]    fill_cnt;
  logic [PTR_W-1:0]    tail;
  logic [PTR_W-1:0]    spec_head;
  logic [PTR_W-1:0]    commit_head;

  logic                run;
  logic                list_empty;
  logic                list_full;
  logic                rel_tag_ok;
  logic                rel_fire;
  logic                rel_ovf;
  logic                commit_fire;
  logic                bypass;

  logic                ram_we;
  logic [IDX_W-1:0]    ram_waddr;
  logic [LOG_PHYS-1:0] ram_wdata;
  logic [LOG_PHYS-1:0] ram_rdata;

  assign run        = (state == FL_RUN);
  assign list_empty = (tail == spec_head);
  // Full counts uncommitted allocations too: those slots still hold live tags.
  assign list_full  = ((tail - commit_head) == PTR_W'(DEPTH));

  // Tag 0 is permanently mapped and never enters the list.
  assign rel_tag_ok  = Release_valid && (Release_phys_reg != '0);
  assign rel_fire    = run && rel_tag_ok && !list_full;
  assign rel_ovf     = run && rel_tag_ok && list_full;
  assign commit_fire = run && Commit_alloc && (commit_head != spec_head);

`ifdef PHYS_FREE_LIST_BYPASS_EN
  assign bypass = rel_fire && list_empty && Alloc_req && !Flush;
`else
  assign bypass = 1'b0;
`endif

  assign Free_reg_avail = run && (!list_empty || bypass);
  assign Free_phys_reg  = bypass ? Release_phys_reg : ram_rdata;
  assign Alloc_grant    = run && Alloc_req && Free_reg_avail && !Flush;
  assign Free_count     = tail - spec_head;

  // The fill sequence owns the write port until the list is running.
  assign ram_we    = run ? rel_fire : 1'b1;
  assign ram_waddr = run ? tail[IDX_W-1:0] : fill_cnt;
  assign ram_wdata = run ? Release_phys_reg : init_tag(fill_cnt);

  free_list_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (LOG_PHYS)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (spec_head[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= FL_INIT;
      fill_cnt     <= '0;
      tail         <= '0;
      spec_head    <= '0;
      commit_head  <= '0;
      Init_done    <= 1'b0;
      Overflow_err <= 1'b0;
    end else begin
      case (state)
        FL_INIT: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == IDX_W'(DEPTH - 1)) begin
            tail      <= PTR_W'(DEPTH);
            state     <= FL_RUN;
            Init_done <= 1'b1;
          end
        end
        FL_RUN: begin
          if (rel_fire)    tail        <= tail + 1'b1;
          if (commit_fire) commit_head <= commit_head + 1'b1;
          // A same-cycle commit moves the rewind target one slot forward.
          if (Flush)            spec_head <= commit_head + PTR_W'(commit_fire);
          else if (Alloc_grant) spec_head <= spec_head + 1'b1;
          if (rel_ovf)     Overflow_err <= 1'b1;
        end
        default: state <= FL_INIT;
      endcase
    end
  end

  // Committing more allocations than were made corrupts the committed head.
  commit_order_chk: assert property (@(posedge CLK) disable iff (!RESET)
    !(run && Commit_alloc && (commit_head == spec_head)));

endmodule
